// File: rtl/div_unit_gen2.sv
// div_unit_gen2: queued iterative divider for DIV/DIVU/REM/REMU with CLZ-based early termination
// and reuse of the last computed quotient/remainder when the complementary op follows.
module div_unit_gen2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int REUSE_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [1:0]            issue_op,
    input  logic [DATA_WIDTH-1:0] issue_rs1,
    input  logic [DATA_WIDTH-1:0] issue_rs2,
    input  logic [ID_WIDTH-1:0]   issue_id,
    output logic                  wb_done,
    input  logic                  wb_ack,
    output logic [DATA_WIDTH-1:0] wb_rd,
    output logic [ID_WIDTH-1:0]   wb_id
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] IDLE = 2'd0, DIVIDE = 2'd1, DONE = 2'd2;

    typedef struct packed {
        logic [W-1:0]        rs1, rs2, m1, m2;
        logic [CW-1:0]       z1, z2;
        logic [1:0]          op;
        logic [ID_WIDTH-1:0] id;
        logic                neg_q, neg_r, div0;
    } entry_t;

    entry_t              in_e, hd;
    entry_t              mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_q, rd_q;
    logic [NW-1:0]       cnt_q;
    logic [1:0]          state_q, state_d;
    logic [W-1:0]        r_q, d_q, q_q, tq_q, tr_q, t1_q, t2_q, quot, rem;
    logic [W-1:0]        c_rs1_q, c_rs2_q, c_m1_q;
    logic [1:0]          c_op_q;
    logic [ID_WIDTH-1:0] c_id_q;
    logic                c_nq_q, c_nr_q, c_d0_q;
    logic [CW-1:0]       k_q, kk;
    logic                ts_q, tv_q, hit_q, hit, push, pop, ge;

    function automatic logic [CW-1:0] clz(input logic [W-1:0] v);
        clz = CW'(W);
        for (int i = 0; i < W; i++)
            if (v[i]) clz = CW'(W - 1 - i);
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Sign-fix at push so the core only ever sees magnitudes
    always_comb begin
        in_e.rs1   = issue_rs1;
        in_e.rs2   = issue_rs2;
        in_e.m1    = (~issue_op[0] & issue_rs1[W-1]) ? -issue_rs1 : issue_rs1;
        in_e.m2    = (~issue_op[0] & issue_rs2[W-1]) ? -issue_rs2 : issue_rs2;
        in_e.z1    = clz(in_e.m1);
        in_e.z2    = clz(in_e.m2);
        in_e.op    = issue_op;
        in_e.id    = issue_id;
        in_e.div0  = issue_rs2 == '0;
        in_e.neg_q = ~issue_op[0] & (issue_rs1[W-1] ^ issue_rs2[W-1]) & ~in_e.div0;
        in_e.neg_r = ~issue_op[0] & issue_rs1[W-1];
    end

    assign hd          = mem_q[rd_q];
    assign issue_ready = cnt_q != NW'(FIFO_DEPTH);
    assign push        = issue_valid & issue_ready;
    assign pop         = cnt_q != '0 && (state_q == IDLE || (state_q == DONE && wb_ack));
    assign hit         = REUSE_EN != 0 && tv_q && !hd.div0 && hd.rs1 == t1_q && hd.rs2 == t2_q && !hd.op[0] == ts_q;
    assign kk          = (hit || hd.div0 || hd.z2 < hd.z1) ? '0 : hd.z2 - hd.z1 + CW'(1);
    assign ge          = r_q >= d_q;
    assign quot        = c_d0_q ? '1 : hit_q ? tq_q : q_q;
    assign rem         = c_d0_q ? c_m1_q : hit_q ? tr_q : r_q;
    assign wb_rd       = c_op_q[1] ? (c_nr_q ? -rem : rem) : (c_nq_q ? -quot : quot);
    assign wb_id       = c_id_q;
    assign wb_done     = state_q == DONE;

    always_comb
        state_d = pop ? DIVIDE :
                  (state_q == DIVIDE && k_q == '0) ? DONE :
                  (state_q == DONE && wb_ack) ? IDLE : state_q;

    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= in_e;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= nxt(wr_q);
            if (pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + NW'(push) - NW'(pop);
        end

    // The divisor is pre-aligned to the dividend's leading one, so only K steps are needed
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            hit_q   <= 1'b0;
            c_rs1_q <= '0;
            c_rs2_q <= '0;
            c_m1_q  <= '0;
            c_op_q  <= '0;
            c_id_q  <= '0;
            c_nq_q  <= 1'b0;
            c_nr_q  <= 1'b0;
            c_d0_q  <= 1'b0;
            tv_q    <= 1'b0;
            ts_q    <= 1'b0;
            t1_q    <= '0;
            t2_q    <= '0;
            tq_q    <= '0;
            tr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                c_rs1_q <= hd.rs1;
                c_rs2_q <= hd.rs2;
                c_m1_q  <= hd.m1;
                c_op_q  <= hd.op;
                c_id_q  <= hd.id;
                c_nq_q  <= hd.neg_q;
                c_nr_q  <= hd.neg_r;
                c_d0_q  <= hd.div0;
                hit_q   <= hit;
                k_q     <= kk;
                r_q     <= hd.m1;
                d_q     <= hd.m2 << (kk - CW'(1));
                q_q     <= '0;
            end else if (state_q == DIVIDE && k_q != '0) begin
                r_q <= ge ? r_q - d_q : r_q;
                d_q <= d_q >> 1;
                q_q <= {q_q[W-2:0], ge};
                k_q <= k_q - CW'(1);
            end else if (state_q == DIVIDE && REUSE_EN != 0 && !hit_q && !c_d0_q) begin
                tv_q <= 1'b1;
                ts_q <= !c_op_q[0];
                t1_q <= c_rs1_q;
                t2_q <= c_rs2_q;
                tq_q <= q_q;
                tr_q <= r_q;
            end
        end
endmodule

// File: tb/tb_div_unit_gen2.sv
// tb_div_unit_gen2: scoreboard bench for div_unit_gen2 (default parameters) covering latency,
// reuse, divide-by-zero, overflow, back-pressure, async reset and random traffic.
module tb_div_unit_gen2;
    logic        clk = 0, rst = 1, issue_valid = 0, wb_ack = 0;
    logic [1:0]  issue_op = '0;
    logic [31:0] issue_rs1 = '0, issue_rs2 = '0;
    logic [2:0]  issue_id = '0;
    logic        issue_ready, wb_done;
    logic [31:0] wb_rd;
    logic [2:0]  wb_id;
    int          n_assert = 0, n_fail = 0;
    logic [31:0] exp_rd[$];
    logic [2:0]  exp_id[$];
    int          exp_k[$];

    div_unit_gen2 dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_id(issue_id),
        .wb_done(wb_done), .wb_ack(wb_ack), .wb_rd(wb_rd), .wb_id(wb_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? sa % sb : sa / sb;
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int kmodel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        int za, zb;
        ma = (!op[0] && a[31]) ? -a : a;
        mb = (!op[0] && b[31]) ? -b : b;
        za = 32;
        zb = 32;
        for (int i = 0; i < 32; i++) begin
            if (ma[i]) za = 31 - i;
            if (mb[i]) zb = 31 - i;
        end
        return (zb - za + 1 > 0) ? zb - za + 1 : 0;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return $urandom();
            1: return 32'($urandom_range(0, 50));
            2: return 32'(0 - $urandom_range(1, 50));
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom_range(0, 3) == 0 ? 32'h0 : $urandom() >> $urandom_range(0, 31);
        endcase
    endfunction

    // Called at a negedge; the push lands on the following posedge and returns at the next negedge
    task automatic do_push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] id);
        int w = 0;
        while (!issue_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_assert++;
            n_fail++;
            $display("FAIL push_timeout: issue_ready stayed 0 for %0d cycles, required 1", w);
        end
        issue_valid = 1;
        issue_op    = op;
        issue_rs1   = a;
        issue_rs2   = b;
        issue_id    = id;
        exp_rd.push_back(model(op, a, b));
        exp_id.push_back(id);
        exp_k.push_back(kmodel(op, a, b));
        @(negedge clk);
        issue_valid = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!wb_done && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] id,
                           output int n, output logic [31:0] rd, output logic [2:0] ido);
        do_push(op, a, b, id);
        wait_done(n);
        rd = wb_rd;
        ido = wb_id;
        wb_ack = 1;
        @(negedge clk);
        wb_ack = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        n_assert++;
        if (wb_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", wb_done); end
        n_assert++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", issue_ready); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [1:0]  ops [6] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b11};
        logic [31:0] as  [6] = '{32'd100, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd5, 32'd5};
        logic [31:0] bs  [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
        int          lat [6] = '{7, 34, 2, 4, 2, 2};
        int          n;
        logic [31:0] rd, er;
        logic [2:0]  ido, ei;
        for (int i = 0; i < 6; i++) begin
            run_one(ops[i], as[i], bs[i], 3'(i + 1), n, rd, ido);
            er = exp_rd.pop_front();
            ei = exp_id.pop_front();
            void'(exp_k.pop_front());
            n_assert++;
            if (n !== lat[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d, required %0d", i, n, lat[i]); end
            n_assert++;
            if (rd !== er) begin n_fail++; $display("FAIL dir%0d_rd: got %h, required %h", i, rd, er); end
            n_assert++;
            if (ido !== ei) begin n_fail++; $display("FAIL dir%0d_id: got %0d, required %0d", i, ido, ei); end
        end
    endtask

    task automatic test_fill_backpressure;
        int          n, got, gap, cyc, k;
        logic [31:0] hr, er;
        logic [2:0]  hi, ei;
        logic        stable;
        do_push(2'b01, 32'd1000, 32'd3, 3'd1);
        do_push(2'b00, 32'hFFFF_FFCE, 32'd7, 3'd2);
        do_push(2'b01, 32'd3, 32'd100, 3'd3);
        n_assert++;
        if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b, required 0", issue_ready); end
        wait_done(n);
        hr = wb_rd;
        hi = wb_id;
        stable = 1;
        repeat (4) begin
            @(negedge clk);
            if (wb_rd !== hr || wb_id !== hi || wb_done !== 1'b1 || issue_ready !== 1'b0) stable = 0;
        end
        n_assert++;
        if (!stable) begin n_fail++; $display("FAIL fill_hold: got rd=%h id=%0d done=%b, required rd=%h id=%0d done=1", wb_rd, wb_id, wb_done, hr, hi); end
        wb_ack = 1;
        got = 0;
        gap = 0;
        cyc = 0;
        while (got < 3 && cyc < 300) begin
            if (wb_done) begin
                er = exp_rd.pop_front();
                ei = exp_id.pop_front();
                k = exp_k.pop_front();
                n_assert++;
                if (wb_rd !== er) begin n_fail++; $display("FAIL fill%0d_rd: got %h, required %h", got, wb_rd, er); end
                n_assert++;
                if (wb_id !== ei) begin n_fail++; $display("FAIL fill%0d_id: got %0d, required %0d", got, wb_id, ei); end
                if (got > 0) begin
                    n_assert++;
                    if (gap !== k + 2) begin n_fail++; $display("FAIL fill%0d_gap: got %0d negedges, required %0d", got, gap, k + 2); end
                end
                got++;
                gap = 0;
            end
            @(negedge clk);
            gap++;
            cyc++;
        end
        wb_ack = 0;
        n_assert++;
        if (got !== 3) begin n_fail++; $display("FAIL fill_count: got %0d results, required 3", got); end
    endtask

    task automatic test_reset_mid;
        int          n;
        logic [31:0] rd;
        logic [2:0]  ido;
        run_one(2'b01, 32'd9, 32'd3, 3'd6, n, rd, ido);
        exp_rd.delete();
        exp_id.delete();
        exp_k.delete();
        for (int i = 1; i <= 3; i++) do_push(2'b01, 32'hFFFF_FFFF, 32'd1, 3'(i));
        repeat (4) @(negedge clk);
        #2 rst = 1;
        #1;
        n_assert++;
        if (wb_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b, required 0", wb_done); end
        n_assert++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b, required 1", issue_ready); end
        exp_rd.delete();
        exp_id.delete();
        exp_k.delete();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        run_one(2'b01, 32'd9, 32'd3, 3'd4, n, rd, ido);
        void'(exp_k.pop_front());
        n_assert++;
        if (n !== 5) begin n_fail++; $display("FAIL rstmid_latency: got %0d, required 5", n); end
        n_assert++;
        if (rd !== exp_rd.pop_front() || rd !== 32'd3) begin n_fail++; $display("FAIL rstmid_rd: got %h, required 00000003", rd); end
        n_assert++;
        if (ido !== exp_id.pop_front()) begin n_fail++; $display("FAIL rstmid_id: got %0d, required 4", ido); end
    endtask

    task automatic test_random;
        localparam int N = 60;
        fork
            begin
                logic [31:0] a, b;
                a = 0;
                b = 1;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if ($urandom_range(0, 3) != 0) begin
                        a = rnd_val();
                        b = rnd_val();
                    end
                    do_push(2'($urandom_range(0, 3)), a, b, 3'(i));
                end
            end
            begin
                int          got = 0, cyc = 0;
                logic [31:0] er;
                logic [2:0]  ei;
                while (got < N && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    wb_ack = $urandom_range(0, 2) != 0;
                    if (wb_done && wb_ack) begin
                        er = exp_rd.pop_front();
                        ei = exp_id.pop_front();
                        void'(exp_k.pop_front());
                        n_assert++;
                        if (wb_rd !== er) begin n_fail++; $display("FAIL rnd%0d_rd: got %h, required %h", got, wb_rd, er); end
                        n_assert++;
                        if (wb_id !== ei) begin n_fail++; $display("FAIL rnd%0d_id: got %0d, required %0d", got, wb_id, ei); end
                        got++;
                    end
                end
                @(negedge clk);
                wb_ack = 0;
                n_assert++;
                if (got !== N) begin n_fail++; $display("FAIL rnd_count: got %0d results, required %0d", got, N); end
            end
        join
        n_assert++;
        if (exp_rd.size() !== 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d pending, required 0", exp_rd.size()); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_fill_backpressure;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
